// File: rtl/serial_to_parallel_8_pkg.sv
// Shared constants and helpers for the serial-to-parallel byte assembler.
//   DATA_W    : assembled word width (one byte)
//   IDX_W     : width of the bit index / bit counter
//   LSB_FIRST : bit order where the first accepted bit lands in position 0
//   MSB_FIRST : bit order where the first accepted bit lands in position 7
//   bit_pos() : maps a bit count to the byte position it writes
package serial_to_parallel_8_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    localparam bit LSB_FIRST = 1'b0;
    localparam bit MSB_FIRST = 1'b1;

    // Position written by the bit with index cnt inside the current byte.
    function automatic logic [IDX_W-1:0] bit_pos(
        input logic [IDX_W-1:0] cnt,
        input bit               order
    );
        logic [IDX_W-1:0] pos;
        if (order == MSB_FIRST) begin
            pos = IDX_W'(DATA_W - 1) - cnt;
        end else begin
            pos = cnt;
        end
        return pos;
    endfunction

endpackage : serial_to_parallel_8_pkg

// File: rtl/serial_to_parallel_8_demux.sv
// 1:8 bit demultiplexer: decodes a 3-bit position into a one-hot write
// enable for the assembly register, gated by in_valid. This is the
// write-side inverse of the 8:1 bit-select mux at the transmit end.
//   pos      : byte position to write
//   in_valid : a bit is being accepted this cycle
//   wr_en_c  : one-hot write enable (all zero when in_valid is low)
module bit_demux_1x8
    import serial_to_parallel_8_pkg::*;
(
    input  logic [IDX_W-1:0]  pos,
    input  logic              in_valid,
    output logic [DATA_W-1:0] wr_en_c
);

    // One-hot decode of pos, qualified by in_valid.
    always_comb begin
        wr_en_c = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (in_valid && (pos == IDX_W'(i))) begin
                wr_en_c[i] = 1'b1;
            end
        end
    end

endmodule : bit_demux_1x8

// File: rtl/serial_to_parallel_8.sv
// Serial-to-parallel byte assembler. Accepts one bit per qualified clock,
// steers it into a byte position chosen by the bit counter and bit order,
// and presents each completed byte on a valid/ready output port.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_bit    : serial data bit
//   in_valid  : in_bit is accepted on this edge
//   start     : frame restart, discards the partial byte
//   out_data  : assembled byte
//   out_valid : out_data holds an unconsumed byte
//   out_ready : consumer takes out_data when out_valid & out_ready
//   bit_cnt   : bits accepted in the current partial byte
//   overrun   : sticky, a completed byte overwrote an unconsumed one
module serial_to_parallel_8
    import serial_to_parallel_8_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_bit,
    input  logic              in_valid,
    input  logic              start,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  bit_cnt,
    output logic              overrun
);

    logic [DATA_W-1:0] asm_reg;
    logic [IDX_W-1:0]  cnt_eff_c;
    logic [IDX_W-1:0]  pos_c;
    logic [DATA_W-1:0] wr_en_c;
    logic [DATA_W-1:0] merged_c;
    logic              byte_done_c;

    // A restart makes the incoming bit the first of a new byte.
    always_comb begin
        cnt_eff_c = bit_cnt;
        if (start) begin
            cnt_eff_c = '0;
        end
        pos_c = bit_pos(cnt_eff_c, MSB_FIRST);
    end

    bit_demux_1x8 u_demux (
        .pos      (pos_c),
        .in_valid (in_valid),
        .wr_en_c  (wr_en_c)
    );

    // Assembly register with the current bit merged in, and completion detect.
    // A restart never completes a byte, even at bit_cnt = 7.
    always_comb begin
        merged_c    = (asm_reg & ~wr_en_c) | ({DATA_W{in_bit}} & wr_en_c);
        byte_done_c = in_valid && !start && (bit_cnt == IDX_W'(DATA_W - 1));
    end

    // Bit counter and assembly register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            asm_reg <= '0;
        end else if (start) begin
            bit_cnt <= in_valid ? IDX_W'(1) : '0;
            asm_reg <= {DATA_W{in_bit}} & wr_en_c;
        end else if (in_valid) begin
            bit_cnt <= bit_cnt + IDX_W'(1);
            asm_reg <= merged_c;
        end
    end

    // Output port: completion wins over consumption in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (byte_done_c) begin
                out_data  <= merged_c;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : serial_to_parallel_8
